// File: rtl/memory_responder.sv
// Multicycle memory responder: one request at a time, programmable wait states,
// byte/half/word lanes with sign/zero extension, one-cycle ready pulse with fault flag.
module memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    output logic [31:0] oData,
    output logic        oReady,
    output logic        oFault,
    output logic        oBusy
);

    localparam int         INDEX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [1:0]    size_r;
    logic          unsigned_r;
    logic          write_r;
    logic          both_r;
    logic [31:0]   data_r;
    logic          ready_r;
    logic          fault_r;
    logic          busy_r;

    logic [31:0]   mem_r [DEPTH_WORDS];

    logic               fault_s;
    logic [INDEX_W-1:0] index_s;
    logic [31:0]        word_s;
    logic [3:0]         mask_s;
    logic [31:0]        merged_s;
    logic [31:0]        read_val_s;

    function automatic logic access_fault(input logic both, input logic [1:0] size,
                                          input logic [31:0] addr);
        logic [32:0] addr_ext;
        addr_ext = {1'b0, addr};
        return both
            || (size == 2'b11)
            || ((size == 2'b01) && addr[0])
            || ((size == 2'b10) && (addr[1:0] != 2'b00))
            || (addr_ext < BASE_EXT)
            || (addr_ext >= LIMIT_EXT);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic zero_ext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = zero_ext ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = zero_ext ? {16'd0, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Fault check, lane merge and read extraction from the latched request
    always_comb begin
        logic [31:0] bit_mask;
        fault_s    = access_fault(both_r, size_r, addr_r);
        index_s    = INDEX_W'((addr_r - BASE_ADDR) >> 2);
        word_s     = mem_r[index_s];
        mask_s     = lane_mask(size_r, addr_r[1:0]);
        bit_mask   = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
        merged_s   = (word_s & ~bit_mask) | ((wdata_r << {addr_r[1:0], 3'b000}) & bit_mask);
        read_val_s = extract_lane(word_s, size_r, addr_r[1:0], unsigned_r);
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            write_r    <= 1'b0;
            both_r     <= 1'b0;
            data_r     <= 32'd0;
            ready_r    <= 1'b0;
            fault_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    fault_r <= 1'b0;
                    if (read || write) begin
                        addr_r     <= iAddress;
                        wdata_r    <= iData;
                        size_r     <= iSize;
                        unsigned_r <= iUnsigned;
                        write_r    <= write;
                        both_r     <= read && write;
                        cnt_r      <= WAIT_LOAD;
                        busy_r     <= 1'b1;
                        state_r    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    ready_r <= 1'b1;
                    fault_r <= fault_s;
                    if (fault_s) begin
                        data_r <= 32'd0;
                    end else if (!write_r) begin
                        data_r <= read_val_s;
                    end else begin
                        data_r <= data_r;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    ready_r <= 1'b0;
                    fault_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    fault_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Array update; reset forces IDLE so an in-flight write never lands
    always_ff @(posedge clock) begin
        if ((state_r == ST_ACCESS) && !fault_s && write_r) begin
            mem_r[index_s] <= merged_s;
        end
    end

    assign oData  = data_r;
    assign oReady = ready_r;
    assign oFault = fault_r;
    assign oBusy  = busy_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: WAIT_CYCLES=2 instance plus a zero-wait instance.
module tb_memory_responder;

    logic        clock_s = 1'b0;
    logic        reset_n_s;
    logic [31:0] address_s;
    logic [31:0] wdata_s;
    logic [1:0]  size_s;
    logic        unsigned_s;
    logic        read_a_s, write_a_s, read_b_s, write_b_s;
    logic [31:0] data_a_s, data_b_s;
    logic        ready_a_s, fault_a_s, busy_a_s;
    logic        ready_b_s, fault_b_s, busy_b_s;

    int          check_count = 0;
    int          error_count = 0;
    logic [31:0] rdata_r;
    logic        flt_r;
    int          lat_r;
    int          ready_pulses_r;
    int          first_ready_r;
    logic        busy_ok_r;

    always #5 clock_s = ~clock_s;

    memory_responder #(.BASE_ADDR(32'h0040_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clock(clock_s), .reset_n(reset_n_s), .iAddress(address_s), .iData(wdata_s),
        .read(read_a_s), .write(write_a_s), .iSize(size_s), .iUnsigned(unsigned_s),
        .oData(data_a_s), .oReady(ready_a_s), .oFault(fault_a_s), .oBusy(busy_a_s)
    );

    memory_responder #(.BASE_ADDR(32'h0040_0000), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_zero (
        .clock(clock_s), .reset_n(reset_n_s), .iAddress(address_s), .iData(wdata_s),
        .read(read_b_s), .write(write_b_s), .iSize(size_s), .iUnsigned(unsigned_s),
        .oData(data_b_s), .oReady(ready_b_s), .oFault(fault_b_s), .oBusy(busy_b_s)
    );

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One request; returns response data, fault and latency (0 when no ready arrived)
    task automatic run_access(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                              output logic [31:0] rdata, output logic flt, output int lat);
        bit done;
        @(negedge clock_s);
        address_s = addr; wdata_s = wd; size_s = sz; unsigned_s = uns;
        if (sel) begin read_b_s = rd; write_b_s = wr; end
        else begin read_a_s = rd; write_a_s = wr; end
        @(posedge clock_s);
        #1;
        read_a_s = 1'b0; write_a_s = 1'b0; read_b_s = 1'b0; write_b_s = 1'b0;
        lat = 0; rdata = 32'd0; flt = 1'b0; done = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!done) begin
                @(negedge clock_s);
                if (sel ? ready_b_s : ready_a_s) begin
                    done = 1'b1;
                    lat = i;
                    rdata = sel ? data_b_s : data_a_s;
                    flt = sel ? fault_b_s : fault_a_s;
                    check_value("busy_at_ready", 32'(sel ? busy_b_s : busy_a_s), 32'd1);
                end
            end
        end
        if (done) begin
            @(negedge clock_s);
            check_value("ready_after", 32'(sel ? ready_b_s : ready_a_s), 32'd0);
            check_value("fault_after", 32'(sel ? fault_b_s : fault_a_s), 32'd0);
            check_value("busy_after", 32'(sel ? busy_b_s : busy_a_s), 32'd0);
        end
    endtask

    logic [31:0] fault_addr [6];
    logic [1:0]  fault_size [6];
    bit          fault_rd   [6];
    bit          fault_wr   [6];

    initial begin
        fault_addr[0] = 32'h0040_0012; fault_size[0] = 2'b10; fault_rd[0] = 1'b1; fault_wr[0] = 1'b0;
        fault_addr[1] = 32'h0040_0011; fault_size[1] = 2'b01; fault_rd[1] = 1'b0; fault_wr[1] = 1'b1;
        fault_addr[2] = 32'h003F_FFFC; fault_size[2] = 2'b10; fault_rd[2] = 1'b1; fault_wr[2] = 1'b0;
        fault_addr[3] = 32'h0040_1000; fault_size[3] = 2'b10; fault_rd[3] = 1'b1; fault_wr[3] = 1'b0;
        fault_addr[4] = 32'h0040_0010; fault_size[4] = 2'b10; fault_rd[4] = 1'b1; fault_wr[4] = 1'b1;
        fault_addr[5] = 32'h0040_0010; fault_size[5] = 2'b11; fault_rd[5] = 1'b1; fault_wr[5] = 1'b0;

        reset_n_s = 1'b0;
        address_s = 32'd0; wdata_s = 32'd0; size_s = 2'b10; unsigned_s = 1'b0;
        read_a_s = 1'b0; write_a_s = 1'b0; read_b_s = 1'b0; write_b_s = 1'b0;
        repeat (3) @(negedge clock_s);
        reset_n_s = 1'b1;
        @(negedge clock_s);
        check_value("rst_data", data_a_s, 32'd0);
        check_value("rst_ready", 32'(ready_a_s), 32'd0);
        check_value("rst_fault", 32'(fault_a_s), 32'd0);
        check_value("rst_busy", 32'(busy_a_s), 32'd0);

        run_access(1'b0, 1'b0, 1'b1, 32'h0040_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("wr_latency", 32'(lat_r), 32'd4);
        check_value("wr_fault", 32'(flt_r), 32'd0);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("rd_word", rdata_r, 32'hDEAD_BEEF);
        check_value("rd_latency", 32'(lat_r), 32'd4);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0013, 32'd0, 2'b00, 1'b0, rdata_r, flt_r, lat_r);
        check_value("rd_byte_s", rdata_r, 32'hFFFF_FFDE);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0013, 32'd0, 2'b00, 1'b1, rdata_r, flt_r, lat_r);
        check_value("rd_byte_u", rdata_r, 32'h0000_00DE);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0012, 32'd0, 2'b01, 1'b0, rdata_r, flt_r, lat_r);
        check_value("rd_half_s", rdata_r, 32'hFFFF_DEAD);

        run_access(1'b0, 1'b0, 1'b1, 32'h0040_0011, 32'h0000_0055, 2'b00, 1'b0, rdata_r, flt_r, lat_r);
        check_value("wr_keeps_data", rdata_r, 32'hFFFF_DEAD);
        check_value("wr_byte_fault", 32'(flt_r), 32'd0);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("rd_merged", rdata_r, 32'hDEAD_55EF);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 2'b01, 1'b1, rdata_r, flt_r, lat_r);
        check_value("rd_half_u_lo", rdata_r, 32'h0000_55EF);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 2'b00, 1'b0, rdata_r, flt_r, lat_r);
        check_value("rd_byte0_s", rdata_r, 32'hFFFF_FFEF);

        for (int k = 0; k < 6; k++) begin
            run_access(1'b0, fault_rd[k], fault_wr[k], fault_addr[k], 32'hAAAA_AAAA,
                       fault_size[k], 1'b0, rdata_r, flt_r, lat_r);
            check_value($sformatf("fault_flag%0d", k), 32'(flt_r), 32'd1);
            check_value($sformatf("fault_data%0d", k), rdata_r, 32'd0);
            check_value($sformatf("fault_lat%0d", k), 32'(lat_r), 32'd4);
        end
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("mem_unchanged", rdata_r, 32'hDEAD_55EF);

        run_access(1'b0, 1'b0, 1'b1, 32'h0040_0FFC, 32'hCAFE_F00D, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("last_wr_fault", 32'(flt_r), 32'd0);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0FFC, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("last_rd", rdata_r, 32'hCAFE_F00D);

        // Strobe during WAIT must be ignored
        @(negedge clock_s);
        address_s = 32'h0040_0010; size_s = 2'b10; read_a_s = 1'b1;
        @(posedge clock_s); #1; read_a_s = 1'b0;
        @(negedge clock_s);
        address_s = 32'h0040_0FFC; read_a_s = 1'b1;
        ready_pulses_r = 0; first_ready_r = 0; busy_ok_r = busy_a_s;
        @(posedge clock_s); #1; read_a_s = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clock_s);
            if (ready_a_s) begin
                ready_pulses_r++;
                if (first_ready_r == 0) begin
                    first_ready_r = c;
                    rdata_r = data_a_s;
                end
            end
            if (first_ready_r == 0 && !busy_a_s) busy_ok_r = 1'b0;
        end
        check_value("ignored_pulses", 32'(ready_pulses_r), 32'd1);
        check_value("ignored_latency", 32'(first_ready_r), 32'd4);
        check_value("ignored_busy", 32'(busy_ok_r), 32'd1);
        check_value("ignored_data", rdata_r, 32'hDEAD_55EF);

        run_access(1'b1, 1'b0, 1'b1, 32'h0040_0000, 32'hA5A5_1234, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("w0_wr_latency", 32'(lat_r), 32'd2);
        run_access(1'b1, 1'b1, 1'b0, 32'h0040_0002, 32'd0, 2'b01, 1'b0, rdata_r, flt_r, lat_r);
        check_value("w0_rd_latency", 32'(lat_r), 32'd2);
        check_value("w0_rd_half", rdata_r, 32'hFFFF_A5A5);

        // Reset during WAIT aborts a write
        run_access(1'b0, 1'b0, 1'b1, 32'h0040_0020, 32'hDEAD_BEEF, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0020, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("pre_abort_rd", rdata_r, 32'hDEAD_BEEF);
        @(negedge clock_s);
        address_s = 32'h0040_0020; wdata_s = 32'h1234_5678; size_s = 2'b10; write_a_s = 1'b1;
        @(posedge clock_s); #1; write_a_s = 1'b0;
        @(negedge clock_s);
        reset_n_s = 1'b0;
        #1;
        check_value("abort_data", data_a_s, 32'd0);
        check_value("abort_ready", 32'(ready_a_s), 32'd0);
        check_value("abort_busy", 32'(busy_a_s), 32'd0);
        check_value("abort_fault", 32'(fault_a_s), 32'd0);
        @(negedge clock_s);
        reset_n_s = 1'b1;
        run_access(1'b0, 1'b1, 1'b0, 32'h0040_0020, 32'd0, 2'b10, 1'b0, rdata_r, flt_r, lat_r);
        check_value("post_abort_rd", rdata_r, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Unified instruction/data memory responder serving the multicycle core's memory port. It accepts one read or write request at a time, inserts a configurable number of wait states, performs byte/half/word accesses with lane selection and sign/zero extension, and returns a one-cycle ready pulse with data or a fault flag. It sits on the core's address/data/read/write bus in place of a zero-latency array, so the control FSM must stall on `oReady`.

## Interface

- Parameters
- `BASE_ADDR`, 32'h0040_0000: byte address of word 0. This is the TEXT segment base.
- `DEPTH_WORDS`, 1024: number of 32-bit words, power of two.
- `WAIT_CYCLES`, 2: wait states inserted before the access, range 0..15.
- Ports
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iAddress` in 32: byte address.
- `iData` in 32: write data, right-aligned (byte in [7:0], half in [15:0]).
- `read` in 1: read request strobe.
- `write` in 1: write request strobe.
- `iSize` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved (faults).
- `iUnsigned` in 1: zero-extend read data when 1, sign-extend when 0.
- `oData` out 32: read result, right-aligned and extended.
- `oReady` out 1: one-cycle response pulse.
- `oFault` out 1: qualifies `oReady`. High when the request was rejected.
- `oBusy` out 1: high from acceptance until the cycle after `oReady`.

## Operation

- The FSM has four states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - When `read` or `write` is sampled high, latch address, data, size, unsigned flag and direction. Set `oBusy`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, otherwise ACCESS.
- WAIT: the counter loads `WAIT_CYCLES`-1 and decrements each cycle. Go to ACCESS when the counter is 0. WAIT lasts exactly `WAIT_CYCLES` cycles.
- ACCESS:
  - Evaluate the fault conditions listed below.
  - If there is no fault and the request is a write, merge the enabled byte lanes into the word at index (addr-BASE_ADDR)>>2. Unselected lanes are unchanged.
  - If there is no fault and the request is a read, extract and extend the lane and register the result into `oData`.
  - If there is a fault, the array is untouched and `oData` is 0.
  - Next state is RESP.
- RESP: `oReady`=1 for one cycle, with `oFault` valid. Next state is IDLE and `oBusy` drops.
- Fault conditions:
  - `read` and `write` both high at acceptance.
  - `iSize`=11.
  - A half access with addr[0]=1.
  - A word access with addr[1:0]≠0.
  - addr < BASE_ADDR or addr ≥ BASE_ADDR + 4·DEPTH_WORDS. The range check is done in 33-bit arithmetic so it cannot wrap.
- Lane select:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],1} and {addr[1],0}.
  - Extension is from bit 7 (byte) or bit 15 (half). Word accesses ignore `iUnsigned`.
- A write response leaves `oData` unchanged. `oData` otherwise holds its value until the next read or fault response.
- Strobes are ignored while `oBusy`=1. The initiator must re-present an ignored request after `oReady`.
- Memory contents are not cleared by reset.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, counter=0, `oData`=0, `oReady`=0, `oFault`=0, `oBusy`=0.
- Request sampled at edge E0 → `oReady` high in the cycle after edge E0+WAIT_CYCLES+1. Request-to-response latency is WAIT_CYCLES+2 cycles.
- Back-to-back throughput: a new request is accepted no earlier than the edge after RESP. The minimum period is WAIT_CYCLES+3 cycles.
- The array write occurs at the edge leaving ACCESS. `reset_n` asserted before that edge aborts the write, leaving memory unmodified and discarding the response.
- Request inputs need only be valid on the accepting edge, because they are latched.
- `oFault` is 0 whenever `oReady` is 0.

## Test plan

- After reset with WAIT_CYCLES=2: write word 32'hDEADBEEF at 0x0040_0010 → `oReady` pulses 4 cycles after the request, `oFault`=0. A subsequent word read at the same address returns 32'hDEADBEEF.
- Byte and half reads from 0x0040_0010:
  - Byte read at 0x0040_0013, signed → 32'hFFFFFFDE.
  - Same byte read, unsigned → 32'h000000DE.
  - Half read at 0x0040_0012, signed → 32'hFFFFDEAD.
- Byte write of 8'h55 at 0x0040_0011, then word read of 0x0040_0010 → 32'hDEAD55EF. The other lanes are preserved.
- Each of the following → `oReady` with `oFault`=1, `oData`=0, and memory unchanged:
  - Word read at 0x0040_0012.
  - Half write at 0x0040_0011.
  - Read at 0x003F_FFFC.
  - Read at BASE+4·DEPTH.
  - `read`=`write`=1.
- A `read` strobe asserted during WAIT is ignored: exactly one `oReady` is produced and `oBusy` stays high until it. Also run with WAIT_CYCLES=0 → latency 2.
- Issue a word write of 32'h12345678 to a location holding 32'hDEADBEEF, and pulse `reset_n` low during the WAIT state → all outputs go to 0 immediately, and a subsequent read returns the old 32'hDEADBEEF.
